// File: rtl/sap_pkg.sv
// Shared types for the parametrised SAP core: opcodes, FSM states,
// and the one-hot select codes for the accumulator load bus.
package sap_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JZ  = 4'h7,
    OP_JC  = 4'h8,
    OP_OUT = 4'h9,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_DECODE,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_EXEC,
    S_OUT_WAIT,
    S_HALT
  } state_t;

  localparam int BUS_W = 3;
  localparam logic [BUS_W-1:0] BUS_NONE = 3'b000;
  localparam logic [BUS_W-1:0] BUS_ALU  = 3'b001;
  localparam logic [BUS_W-1:0] BUS_MEM  = 3'b010;
  localparam logic [BUS_W-1:0] BUS_IMM  = 3'b100;

  function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
    return (opc == OP_LDA) || (opc == OP_ADD) ||
           (opc == OP_SUB) || (opc == OP_STA);
  endfunction

endpackage

// File: rtl/sap_alu_p.sv
// Combinational add/subtract unit, one bit wider internally so the
// top bit is carry-out on add and borrow on subtract.
module sap_alu_p #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;

  always_comb begin
    if (sub) sum = {1'b0, a} - {1'b0, b};
    else     sum = {1'b0, a} + {1'b0, b};
  end

  assign result = sum[DATA_W-1:0];
  assign carry  = sum[DATA_W];
  assign zero   = (result == '0);

endmodule

// File: rtl/sap_core_p.sv
// Parametrised SAP accumulator core with req/ack memory and valid/ready
// output port. Define SAP_STEP_EN for single-step operation via 'step'.
module sap_core_p
  import sap_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int ADDR_W = 4,
  localparam int WORD_W = OPC_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SAP_STEP_EN
  input  logic              step,
`endif
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] port_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted
);

`ifdef SAP_STEP_EN
  localparam state_t S_NEXT = S_IDLE;
`else
  localparam state_t S_NEXT = S_FETCH_REQ;
`endif

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [WORD_W-1:0]   ir_q;
  logic                z_q;
  logic                c_q;

  logic [OPC_W-1:0]    opc;
  logic [DATA_W-1:0]   opnd;
  logic [ADDR_W-1:0]   iaddr;
  logic [DATA_W-1:0]   mem_d;

  assign opc   = ir_q[WORD_W-1 -: OPC_W];
  assign opnd  = ir_q[DATA_W-1:0];
  assign iaddr = opnd[ADDR_W-1:0];
  assign mem_d = mem_rdata[DATA_W-1:0];

  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_z;

  sap_alu_p #(.DATA_W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .sub    (opc == OP_SUB),
    .result (alu_res),
    .carry  (alu_c),
    .zero   (alu_z)
  );

  logic [BUS_W-1:0]  bus_sel;
  logic [DATA_W-1:0] bus;
  logic              bus_c;
  logic              bus_z;

  always_comb begin
    bus_sel = BUS_NONE;
    if (state_q == S_MEM_WAIT && mem_ack && opc == OP_LDA)
      bus_sel = BUS_MEM;
    else if (state_q == S_EXEC) begin
      if (opc == OP_LDI)
        bus_sel = BUS_IMM;
      else if (opc == OP_ADD || opc == OP_SUB)
        bus_sel = BUS_ALU;
    end
  end

  // Loads clear carry; only the ALU path produces one.
  always_comb begin
    bus   = '0;
    bus_c = 1'b0;
    bus_z = 1'b1;
    unique case (1'b1)
      bus_sel[0]: begin
        bus   = alu_res;
        bus_c = alu_c;
        bus_z = alu_z;
      end
      bus_sel[1]: begin
        bus   = mem_d;
        bus_z = (mem_d == '0);
      end
      bus_sel[2]: begin
        bus   = opnd;
        bus_z = (opnd == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_NEXT;
      pc_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      ir_q      <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      port_out  <= '0;
      out_valid <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
    end else begin
      unique case (state_q)
`ifdef SAP_STEP_EN
        S_IDLE: if (step) state_q <= S_FETCH_REQ;
`else
        S_IDLE: state_q <= S_FETCH_REQ;
`endif
        S_FETCH_REQ: begin
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pc_q;
          state_q  <= S_FETCH_WAIT;
        end
        S_FETCH_WAIT: if (mem_ack) begin
          ir_q    <= mem_rdata;
          pc_q    <= pc_q + ADDR_W'(1);
          mem_req <= 1'b0;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          state_q <= S_NEXT;
          if (is_mem_op(opc))
            state_q <= S_MEM_REQ;
          else begin
            case (opc)
              OP_LDI: state_q <= S_EXEC;
              OP_JMP: pc_q <= iaddr;
              OP_JZ:  if (z_q) pc_q <= iaddr;
              OP_JC:  if (c_q) pc_q <= iaddr;
              OP_OUT: begin
                port_out  <= a_q;
                out_valid <= 1'b1;
                state_q   <= S_OUT_WAIT;
              end
              OP_HLT: begin
                halted  <= 1'b1;
                state_q <= S_HALT;
              end
              default: ;
            endcase
          end
        end
        S_MEM_REQ: begin
          mem_req   <= 1'b1;
          mem_we    <= (opc == OP_STA);
          mem_addr  <= iaddr;
          mem_wdata <= {{OPC_W{1'b0}}, a_q};
          state_q   <= S_MEM_WAIT;
        end
        S_MEM_WAIT: if (mem_ack) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          if (opc == OP_ADD || opc == OP_SUB) begin
            b_q     <= mem_d;
            state_q <= S_EXEC;
          end else
            state_q <= S_NEXT;
        end
        S_EXEC: state_q <= S_NEXT;
        S_OUT_WAIT: if (out_valid && out_ready) begin
          out_valid <= 1'b0;
          state_q   <= S_NEXT;
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_NEXT;
      endcase
      if (|bus_sel) begin
        a_q <= bus;
        z_q <= bus_z;
        c_q <= bus_c;
      end
    end
  end

endmodule

// File: doc/sap_core_p.md
Name: sap_core_p

Overview:
- Parametrised successor of the 4-bit SAP CPU top level: accumulator machine with A/B registers, PC, IR, ALU flags and a multi-cycle control FSM.
- Program/data memory sits outside the core behind a req/ack handshake.
- Output port uses a valid/ready handshake, so a slow consumer stalls the core.
- Adds SUB, STA, conditional jumps, carry/zero flags and HALT.

Parameters:
- DATA_W, 4: datapath width of A, B, ALU and output port; range 4..16.
- ADDR_W, 4: memory address width and PC width; must be <= DATA_W.
- WORD_W, 4+DATA_W (derived, localparam): memory word = {opcode[3:0], operand[DATA_W-1:0]}.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- mem_req  out  1  memory access request, held until ack
- mem_we  out  1  1 = write (STA), 0 = read
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  WORD_W  write data {4'h0, A}
- mem_rdata  in  WORD_W  read data, valid when mem_ack=1
- mem_ack  in  1  one-cycle completion strobe
- port_out  out  DATA_W  output register value
- out_valid  out  1  port_out holds new data
- out_ready  in  1  consumer accepts
- halted  out  1  core in HALT

Behaviour:
- Reset (takes priority over everything, including mid-handshake): PC=0, A=0, B=0, IR=0, Z=0, C=0, port_out=0, out_valid=0, mem_req=0, mem_we=0, halted=0, state=FETCH_REQ.
- FSM states: FETCH_REQ, FETCH_WAIT, DECODE, MEM_REQ, MEM_WAIT, EXEC, OUT_WAIT, HALT.
- FETCH_REQ: mem_req=1, mem_we=0, mem_addr=PC; goes to FETCH_WAIT.
- FETCH_WAIT: holds the request. On mem_ack: IR<=mem_rdata, PC<=PC+1 (wraps 2^ADDR_W-1 -> 0), mem_req<=0, goes to DECODE.
- Ack latency: 0..N cycles; ack in the first wait cycle is legal.
- mem_ack while not in a WAIT state is ignored.
- Operand field: op=IR[DATA_W-1:0]; addr=op[ADDR_W-1:0].
- Opcodes and DECODE transitions:
  - 0 NOP -> FETCH_REQ
  - 1 LDA -> MEM_REQ (read); A<=mem[addr] low DATA_W bits
  - 2 ADD -> MEM_REQ (read); B<=mem; then EXEC A<=A+B
  - 3 SUB -> MEM_REQ (read); B<=mem; then EXEC A<=A-B
  - 4 STA -> MEM_REQ (write A)
  - 5 LDI -> EXEC; A<=op
  - 6 JMP: PC<=addr
  - 7 JZ: PC<=addr if Z
  - 8 JC: PC<=addr if C
  - 9 OUT -> OUT_WAIT
  - F HLT -> HALT
  - others: treated as NOP
- Arithmetic is DATA_W+1 wide internally.
  - ADD: C = carry-out.
  - SUB: C = borrow (A<B).
  - Z = (new A == 0).
  - Flags update only on LDA, ADD, SUB, LDI; jumps and stores leave flags unchanged.
- Cycle counts with single-cycle ack:
  - NOP/JMP: 3 cycles.
  - LDI: 4 cycles.
  - LDA/STA: 5 cycles.
  - ADD/SUB: 6 cycles.
- OUT_WAIT: port_out<=A and out_valid<=1 on entry. Stays until out_valid && out_ready. The handshake cycle clears out_valid and goes to FETCH_REQ.
- out_ready asserted early (before out_valid) has no effect.
- HALT: halted=1, no further memory requests. Exits only via rst.
- Only one bus source per cycle: the internal bus select is one-hot, with no tri-states.

Optional Feature:
- SAP_STEP_EN defined:
  - Adds input step (1 bit).
  - FETCH_REQ is entered only from a new IDLE state, which waits for step=1. Exactly one instruction executes per step pulse.
  - Reset goes to IDLE.
- SAP_STEP_EN undefined:
  - No step port.
  - Core free-runs as described above.

Decomposition:
- Package sap_pkg:
  - opcode enum (NOP..HLT, 4-bit)
  - FSM state enum
  - OPC_W=4 constant
- Natural sub-module: sap_alu_p.
  - Combinational, DATA_W param.
  - Inputs a, b, sub.
  - Outputs result, carry, zero.
- Register, PC and FSM logic stay in sap_core_p.

Test Plan:
- Reset mid-FETCH_WAIT (mem_req=1, no ack), then rst for 1 cycle -> next cycle mem_req=0, PC=0, all outputs at reset values; fetch restarts from addr 0.
- DATA_W=4, program LDI 9; ADD [5] with mem[5]=8 -> A=1, C=1, Z=0. Then SUB [6] with mem[6]=1 -> A=0, Z=1, C=0.
- LDI 0; JZ 0xA; at 0xA STA 0xE -> mem write to addr 0xE, data 0. Instruction at 0x2 is never fetched.
- OUT with out_ready held low for 5 cycles -> out_valid stays 1, port_out=A, no mem_req; releases one cycle after out_ready=1.
- Random ack delays 0..7 on a 16-instruction program ending in HLT at 0xF -> architectural results match a reference model; halted=1; mem_req stays 0 after halt.
- PC wrap: JMP 0xF, where 0xF holds NOP -> next fetch address is 0x0.
